// File: rtl/mem_sweep_ctrl_if.sv
// Handshake and SRAM bus bundle for mem_sweep_ctrl; the controller takes the
// slave side, the driver and SRAM model sit on the master side.
interface mem_sweep_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              start;
    logic              abort;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] fail_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_cs;
    logic              mem_we;
    logic              mem_oe;

    modport master (
        output start, abort, mode, base_addr, last_addr, mem_rdata,
        input  busy, done, err, err_cnt, fail_addr,
        input  mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
    );

    modport slave (
        input  start, abort, mode, base_addr, last_addr, mem_rdata,
        output busy, done, err, err_cnt, fail_addr,
        output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe
    );
endinterface

// File: rtl/mem_sweep_ctrl.sv
// SRAM sweep controller: writes an incrementing pattern over an address window
// and/or reads it back, tracking mismatch status, count and first failing address.
module mem_sweep_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int SEED   = 1
) (
    input logic             clk,
    input logic             reset,
    mem_sweep_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, W_ADDR, W_PULSE, W_HOLD, R_ADDR, R_SAMPLE, DONE
    } state_t;

    localparam logic [DATA_W-1:0] SEED_PAT = DATA_W'(SEED);

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] span_q, span_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] pat_q, pat_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic              last_word;

    // span holds N-1, so the final word is reached when the offset equals it
    assign last_word = (offset_q == span_q);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        base_d      = base_q;
        span_d      = span_q;
        offset_d    = offset_q;
        addr_d      = addr_q;
        pat_d       = pat_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;

        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mode_d      = bus.mode;
                        base_d      = bus.base_addr;
                        span_d      = bus.last_addr - bus.base_addr;
                        offset_d    = '0;
                        addr_d      = bus.base_addr;
                        pat_d       = SEED_PAT;
                        err_d       = 1'b0;
                        err_cnt_d   = '0;
                        fail_addr_d = '0;
                        state_d     = (bus.mode == 2'b01) ? R_ADDR : W_ADDR;
                    end
                end
                W_ADDR:  state_d = W_PULSE;
                W_PULSE: state_d = W_HOLD;
                W_HOLD: begin
                    if (!last_word) begin
                        offset_d = offset_q + 1'b1;
                        addr_d   = addr_q + 1'b1;
                        pat_d    = pat_q + 1'b1;
                        state_d  = W_ADDR;
                    end else if (mode_q == 2'b00) begin
                        state_d = DONE;
                    end else begin
                        // fill complete: rewind to the window start for readback
                        offset_d = '0;
                        addr_d   = base_q;
                        pat_d    = SEED_PAT;
                        state_d  = R_ADDR;
                    end
                end
                R_ADDR: state_d = R_SAMPLE;
                R_SAMPLE: begin
                    if (bus.mem_rdata != pat_q) begin
                        err_d = 1'b1;
                        if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
                        if (!err_q) fail_addr_d = addr_q;
                    end
                    if (last_word) begin
                        state_d = DONE;
                    end else begin
                        offset_d = offset_q + 1'b1;
                        addr_d   = addr_q + 1'b1;
                        pat_d    = pat_q + 1'b1;
                        state_d  = R_ADDR;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= 2'b00;
            base_q      <= '0;
            span_q      <= '0;
            offset_q    <= '0;
            addr_q      <= '0;
            pat_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            span_q      <= span_d;
            offset_q    <= offset_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    // strobes decode the state register only, so we and oe can never overlap
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.mem_cs    = (state_q == W_ADDR) || (state_q == W_PULSE) || (state_q == W_HOLD) ||
                           (state_q == R_ADDR) || (state_q == R_SAMPLE);
    assign bus.mem_we    = (state_q == W_PULSE);
    assign bus.mem_oe    = (state_q == R_ADDR) || (state_q == R_SAMPLE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = pat_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.fail_addr = fail_addr_q;
endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Scoreboard bench for mem_sweep_ctrl with a registered-read SRAM model that
// can corrupt selected addresses.
module tb_mem_sweep_ctrl;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int SEED = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_sweep_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_sweep_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SEED(SEED)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] mem     [2**AW];
    logic          corrupt [2**AW];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_oe) bus.mem_rdata <= corrupt[bus.mem_addr] ? 8'hFF : mem[bus.mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW+DW-1:0] exp_wr_q [$];
    logic [AW-1:0]    exp_rd_q [$];
    logic             exp_err;
    logic [AW:0]      exp_cnt;
    logic [AW-1:0]    exp_fail;
    int               exp_cyc;
    int               start_cyc;

    logic rd_phase = 1'b0;
    always @(negedge clk) begin
        if (bus.mem_cs || bus.mem_we || bus.mem_oe) begin
            check("we_and_oe", 32'(bus.mem_we & bus.mem_oe), 0);
            check("we_without_cs", 32'(bus.mem_we & ~bus.mem_cs), 0);
        end
        if (bus.mem_we) begin
            check("wr_expected", 32'(exp_wr_q.size() > 0), 1);
            if (exp_wr_q.size() > 0)
                check("wr_addr_data", 32'({bus.mem_addr, bus.mem_wdata}), 32'(exp_wr_q.pop_front()));
        end
        if (bus.mem_oe && !rd_phase) begin
            check("rd_expected", 32'(exp_rd_q.size() > 0), 1);
            if (exp_rd_q.size() > 0)
                check("rd_addr", 32'(bus.mem_addr), 32'(exp_rd_q.pop_front()));
        end
        rd_phase <= bus.mem_oe ? ~rd_phase : 1'b0;
    end

    // Called at a falling edge; predicts the whole sweep, then issues start.
    task automatic start_sweep(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW-1:0] l);
        int            n;
        logic [AW-1:0] a;
        logic [DW-1:0] p;
        logic [DW-1:0] rv;
        n        = int'(AW'(l - b)) + 1;
        exp_err  = 1'b0;
        exp_cnt  = '0;
        exp_fail = '0;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            p = DW'(SEED + i);
            if (m != 2'b01) exp_wr_q.push_back({a, p});
            if (m != 2'b00) begin
                exp_rd_q.push_back(a);
                rv = corrupt[a] ? 8'hFF : ((m == 2'b01) ? mem[a] : p);
                if (rv != p) begin
                    if (!exp_err) exp_fail = a;
                    exp_err = 1'b1;
                    if (!(&exp_cnt)) exp_cnt = exp_cnt + 1'b1;
                end
            end
        end
        exp_cyc = (m == 2'b00) ? 3 * n + 1 : (m == 2'b01) ? 2 * n + 1 : 5 * n + 1;
        bus.start     = 1'b1;
        bus.mode      = m;
        bus.base_addr = b;
        bus.last_addr = l;
        @(posedge clk);
        @(negedge clk);
        start_cyc     = cyc;
        bus.start     = 1'b0;
        bus.mode      = 2'($urandom);
        bus.base_addr = AW'($urandom);
        bus.last_addr = AW'($urandom);
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (!bus.done && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 1);
        check({tag, "_latency"}, 32'(cyc - start_cyc + 1), 32'(exp_cyc));
        check({tag, "_busy_in_done"}, 32'(bus.busy), 1);
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'(exp_cnt));
        check({tag, "_fail_addr"}, 32'(bus.fail_addr), 32'(exp_fail));
        check({tag, "_wr_left"}, 32'(exp_wr_q.size()), 0);
        check({tag, "_rd_left"}, 32'(exp_rd_q.size()), 0);
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(bus.busy), 0);
        check({tag, "_done_after"}, 32'(bus.done), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_err"}, 32'(bus.err), 0);
        check({tag, "_err_cnt"}, 32'(bus.err_cnt), 0);
        check({tag, "_fail_addr"}, 32'(bus.fail_addr), 0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
        check({tag, "_cs"}, 32'(bus.mem_cs), 0);
        check({tag, "_we"}, 32'(bus.mem_we), 0);
        check({tag, "_oe"}, 32'(bus.mem_oe), 0);
    endtask

    task automatic clear_corrupt();
        for (int k = 0; k < 2**AW; k++) corrupt[k] = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.mode      = 2'b00;
        bus.base_addr = '0;
        bus.last_addr = '0;
        bus.mem_rdata = '0;
        for (int k = 0; k < 2**AW; k++) mem[k] = '0;
        clear_corrupt();

        #2 reset = 1'b1;
        #1 check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // full fill-then-verify, ideal memory
        start_sweep(2'b10, 5'd0, 5'd31);
        wait_done("fv_clean");

        // same sweep with two corrupted read locations
        corrupt[7]  = 1'b1;
        corrupt[20] = 1'b1;
        start_sweep(2'b10, 5'd0, 5'd31);
        wait_done("fv_corrupt");

        // verify-only over existing content, first failure must be kept
        clear_corrupt();
        corrupt[6] = 1'b1;
        corrupt[8] = 1'b1;
        start_sweep(2'b01, 5'd5, 5'd9);
        wait_done("verify_only");

        // wrapping fill-only window
        clear_corrupt();
        start_sweep(2'b00, 5'd30, 5'd1);
        wait_done("fill_wrap");

        // mode 11 behaves as fill-then-verify, single word
        start_sweep(2'b11, 5'd3, 5'd3);
        wait_done("mode11_single");

        // abort in the write pulse of word 3
        start_sweep(2'b00, 5'd0, 5'd31);
        while (exp_wr_q.size() > 4) void'(exp_wr_q.pop_back());
        repeat (10) @(negedge clk);
        check("abort_in_pulse_we", 32'(bus.mem_we), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_cs", 32'(bus.mem_cs), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 0);
        end
        check("abort_wr_left", 32'(exp_wr_q.size()), 0);

        // asynchronous reset during a read sample
        clear_corrupt();
        corrupt[1] = 1'b1;
        start_sweep(2'b01, 5'd0, 5'd31);
        repeat (5) @(negedge clk);
        check("pre_rst_oe", 32'(bus.mem_oe), 1);
        check("pre_rst_err", 32'(bus.err), 1);
        check("pre_rst_err_cnt", 32'(bus.err_cnt), 1);
        check("pre_rst_fail_addr", 32'(bus.fail_addr), 1);
        #2 reset = 1'b1;
        #1 check_all_zero("mid_rst");
        exp_wr_q.delete();
        exp_rd_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(bus.busy), 0);

        // a start raised mid-sweep must be ignored
        start_sweep(2'b00, 5'd4, 5'd7);
        repeat (4) @(negedge clk);
        bus.start     = 1'b1;
        bus.mode      = 2'b01;
        bus.base_addr = 5'd20;
        bus.last_addr = 5'd21;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("start_ignored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
